// File: rtl/noc_mmio_bridge.sv
// rtl/noc_mmio_bridge.sv - PicoRV32 look-ahead bus to Hoplite NoC bridge with TX/RX FIFOs.
// Optional RX interrupt enabled by defining NOC_MMIO_IRQ_EN.
module noc_mmio_bridge #(
  parameter int          COORD_BITS   = 1,
  parameter int          DATA_WIDTH   = 32,
  parameter int          TX_DEPTH     = 8,
  parameter int          RX_DEPTH     = 8,
  parameter int          LED_WIDTH    = 4,
  parameter int          SWITCH_WIDTH = 1,
  parameter logic [31:0] BASE_ADDR    = 32'h2000_0000
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    bus_la_read,
  input  logic                    bus_la_write,
  input  logic [31:0]             bus_la_addr,
  input  logic [31:0]             bus_la_wdata,
  output logic [31:0]             rd_data,
  output logic                    rd_hit,
  input  logic [SWITCH_WIDTH-1:0] switch,
  output logic [LED_WIDTH-1:0]    led,
  output logic [COORD_BITS-1:0]   pkt_x,
  output logic [COORD_BITS-1:0]   pkt_y,
  output logic [DATA_WIDTH-1:0]   pkt_data,
  output logic                    pkt_valid,
  output logic                    pkt_last,
  input  logic                    pkt_ready,
  input  logic [DATA_WIDTH-1:0]   rx_data,
  input  logic                    rx_valid,
  output logic                    rx_ready,
  output logic                    irq
);
  localparam int TPW = $clog2(TX_DEPTH);
  localparam int TCW = TPW + 1;
  localparam int RPW = $clog2(RX_DEPTH);
  localparam int RCW = RPW + 1;
  localparam logic [TCW-1:0] TX_FULL = TCW'(TX_DEPTH);
  localparam logic [RCW-1:0] RX_FULL = RCW'(RX_DEPTH);

  typedef enum logic {IDLE, SEND} state_t;
  state_t state;

  logic [31:0]           offset;
  logic                  in_win, wr_en, rd_en;
  logic [3:0]            idx;
  logic [COORD_BITS-1:0] dest_x, dest_y;
  logic [DATA_WIDTH-1:0] tx_mem [TX_DEPTH];
  logic [DATA_WIDTH-1:0] rx_mem [RX_DEPTH];
  logic [TPW-1:0]        tx_wr, tx_rd;
  logic [RPW-1:0]        rx_wr, rx_rd;
  logic [TCW-1:0]        tx_count;
  logic [RCW-1:0]        rx_count;
  logic                  tx_err, rx_underflow;
  logic                  tx_push, tx_pop, send_ok, rx_push, rx_pop;
  logic                  wr_txd, wr_send, wr_stat, rd_rxd;
  logic [31:0]           rd_val;
  logic                  unused_ok;

  assign offset  = bus_la_addr - BASE_ADDR;
  assign in_win  = (offset[31:6] == 26'd0);
  assign idx     = offset[5:2];
  assign wr_en   = bus_la_write && in_win;
  assign rd_en   = bus_la_read && in_win;
  assign wr_txd  = wr_en && (idx == 4'h2);
  assign wr_send = wr_en && (idx == 4'h3);
  assign wr_stat = wr_en && (idx == 4'h4);
  assign rd_rxd  = rd_en && (idx == 4'h5);

  // The FIFO is frozen while a packet is in flight, which keeps pkt_* stable under stall.
  assign tx_push = wr_txd && (tx_count != TX_FULL) && (state == IDLE);
  assign send_ok = wr_send && (tx_count != '0) && (state == IDLE);
  assign tx_pop  = (state == SEND) && pkt_ready;
  assign rx_ready = (rx_count != RX_FULL);
  assign rx_push = rx_valid && rx_ready;
  assign rx_pop  = rd_rxd && (rx_count != '0);

  assign pkt_valid = (state == SEND);
  assign pkt_data  = pkt_valid ? tx_mem[tx_rd] : '0;
  assign pkt_last  = pkt_valid && (tx_count == TCW'(1));
  assign unused_ok = &{1'b0, offset[1:0], bus_la_wdata};

`ifdef NOC_MMIO_IRQ_EN
  logic irq_en;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_en <= 1'b0;
      irq    <= 1'b0;
    end else begin
      if (wr_en && (idx == 4'h8)) irq_en <= bus_la_wdata[0];
      irq <= irq_en && (rx_count != '0);
    end
  end
`else
  assign irq = 1'b0;
`endif

  always_comb begin
    rd_val = '0;
    case (idx)
      4'h4: begin
        rd_val[15:0]  = 16'(rx_count);
        rd_val[16]    = (state == SEND);
        rd_val[17]    = tx_err;
        rd_val[18]    = rx_underflow;
        rd_val[31:19] = 13'(tx_count);
      end
      4'h5: rd_val = (rx_count != '0) ? 32'(rx_mem[rx_rd]) : '0;
      4'h6: rd_val = 32'(led);
      4'h7: rd_val = 32'(switch);
`ifdef NOC_MMIO_IRQ_EN
      4'h8: rd_val = {31'd0, irq_en};
`endif
      default: rd_val = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr] <= bus_la_wdata[DATA_WIDTH-1:0];
    if (rx_push) rx_mem[rx_wr] <= rx_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      rd_data      <= '0;
      rd_hit       <= 1'b0;
      led          <= '0;
      dest_x       <= '0;
      dest_y       <= '0;
      pkt_x        <= '0;
      pkt_y        <= '0;
      tx_wr        <= '0;
      tx_rd        <= '0;
      tx_count     <= '0;
      rx_wr        <= '0;
      rx_rd        <= '0;
      rx_count     <= '0;
      tx_err       <= 1'b0;
      rx_underflow <= 1'b0;
    end else begin
      rd_hit  <= rd_en;
      rd_data <= rd_en ? rd_val : '0;
      if (wr_en && (idx == 4'h0)) dest_x <= bus_la_wdata[COORD_BITS-1:0];
      if (wr_en && (idx == 4'h1)) dest_y <= bus_la_wdata[COORD_BITS-1:0];
      if (wr_en && (idx == 4'h6)) led <= bus_la_wdata[LED_WIDTH-1:0];

      if (tx_push) tx_wr <= tx_wr + TPW'(1);
      if (tx_pop)  tx_rd <= tx_rd + TPW'(1);
      if (tx_push && !tx_pop)      tx_count <= tx_count + TCW'(1);
      else if (!tx_push && tx_pop) tx_count <= tx_count - TCW'(1);

      if (rx_push) rx_wr <= rx_wr + RPW'(1);
      if (rx_pop)  rx_rd <= rx_rd + RPW'(1);
      if (rx_push && !rx_pop)      rx_count <= rx_count + RCW'(1);
      else if (!rx_push && rx_pop) rx_count <= rx_count - RCW'(1);

      if ((wr_txd && !tx_push) || (wr_send && !send_ok)) tx_err <= 1'b1;
      else if (wr_stat && bus_la_wdata[17])               tx_err <= 1'b0;
      if (rd_rxd && (rx_count == '0))                     rx_underflow <= 1'b1;
      else if (wr_stat && bus_la_wdata[18])               rx_underflow <= 1'b0;

      case (state)
        IDLE: if (send_ok) begin
          state <= SEND;
          pkt_x <= dest_x;
          pkt_y <= dest_y;
        end
        SEND: if (pkt_ready && (tx_count == TCW'(1))) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
